// File: rtl/pwm_speed_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_speed_gen
// Purpose  : Speed-level tracker (0..9) with a 10-slot motor PWM and
//            active-low 7-segment level display.
// Revision : 1.0
// ============================================================================
module pwm_speed_gen #(
  parameter int CLK_DIV     = 50,
  parameter int START_LEVEL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       swt_inc,
  input  logic       swt_dec,
  output logic       pwm_out,
  output logic [3:0] level,
  output logic [6:0] seg,
  output logic       period_start
);

  localparam int              PW           = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   c_PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]      c_SLOT_LAST  = 4'd9;
  localparam logic [3:0]      c_LEVEL_MAX  = 4'd9;
  localparam logic [3:0]      c_START      = 4'(START_LEVEL);

  // Bit 0 carries the increase switch, bit 1 the decrease switch.
  logic [1:0]    r_sw_sync1;
  logic [1:0]    r_sw_sync2;
  logic [1:0]    r_sw_prev;
  logic          r_enable_q;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_slot;
  logic [3:0]    r_shadow;
  logic [3:0]    r_level;
  logic          r_pwm;
  logic          r_period_start;

  logic [1:0]    w_sw_edge;
  logic          w_start;
  logic          w_tick;
  logic          w_period_end;
  logic [3:0]    w_level_nxt;

  assign w_sw_edge    = r_sw_sync2 & ~r_sw_prev;
  assign w_start      = enable & ~r_enable_q;
  assign w_tick       = (r_presc == c_PRESC_LAST);
  assign w_period_end = w_tick & (r_slot == c_SLOT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_sync1 <= 2'b00;
      r_sw_sync2 <= 2'b00;
      r_sw_prev  <= 2'b00;
      r_enable_q <= 1'b0;
    end else begin
      r_sw_sync1 <= {swt_dec, swt_inc};
      r_sw_sync2 <= r_sw_sync1;
      r_sw_prev  <= r_sw_sync2;
      r_enable_q <= enable;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (!enable) begin
      w_level_nxt = 4'd0;
    end else if (w_start) begin
      w_level_nxt = c_START;
    end else begin
      case (w_sw_edge)
        2'b01:   if (r_level != c_LEVEL_MAX) w_level_nxt = r_level + 4'd1;
        2'b10:   if (r_level != 4'd0)        w_level_nxt = r_level - 4'd1;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 4'd0;
    end else begin
      r_level <= w_level_nxt;
    end
  end

  // Counters sit at zero while stopped and restart from zero on a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_slot  <= 4'd0;
    end else if (!enable || w_start) begin
      r_presc <= '0;
      r_slot  <= 4'd0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_slot  <= (r_slot == c_SLOT_LAST) ? 4'd0 : r_slot + 4'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // The shadow only moves at a period boundary so a period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= 4'd0;
    end else if (!enable) begin
      r_shadow <= 4'd0;
    end else if (w_start) begin
      r_shadow <= c_START;
    end else if (w_period_end) begin
      r_shadow <= r_level;
    end
  end

  // enable_q keeps the held-at-zero start cycle from producing an extra pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= enable & (r_slot < r_shadow);
      r_period_start <= enable & r_enable_q & (r_presc == '0) & (r_slot == 4'd0);
    end
  end

  always_comb begin
    seg = 7'b0111111;
    case (r_level)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end

  assign pwm_out      = r_pwm;
  assign level        = r_level;
  assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_speed_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_speed_gen
// Purpose  : Directed + randomized bench for pwm_speed_gen against a
//            history-based reference model.
// Revision : 1.0
// ============================================================================
module tb_pwm_speed_gen;

  localparam int CLK_DIV     = 4;
  localparam int START_LEVEL = 5;
  localparam int PERIOD      = 10 * CLK_DIV;
  localparam int HMAX        = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       swt_inc = 1'b0;
  logic       swt_dec = 1'b0;
  logic       pwm_out;
  logic [3:0] level;
  logic [6:0] seg;
  logic       period_start;

  pwm_speed_gen #(.CLK_DIV(CLK_DIV), .START_LEVEL(START_LEVEL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .swt_inc(swt_inc), .swt_dec(swt_dec),
    .pwm_out(pwm_out), .level(level), .seg(seg), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Per-edge history of sampled inputs and the expected level after each edge.
  bit en_h  [HMAX];
  bit inc_h [HMAX];
  bit dec_h [HMAX];
  int lvl_h [HMAX];
  int n = 4;
  int s = 4;
  int exp_pwm = 0;
  int exp_ps  = 0;
  int m_k, m_p, m_per, m_duty, m_lvl;
  bit m_ie, m_de;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (n < HMAX - 1) n++;
    if (rst) begin
      en_h[n] = 0; inc_h[n] = 0; dec_h[n] = 0; lvl_h[n] = 0;
      exp_pwm = 0; exp_ps = 0;
    end else begin
      en_h[n] = enable; inc_h[n] = swt_inc; dec_h[n] = swt_dec;
      if (!enable) begin
        m_lvl = 0;
      end else if (!en_h[n-1]) begin
        m_lvl = START_LEVEL;
        s = n;
      end else begin
        m_ie  = inc_h[n-2] && !inc_h[n-3];
        m_de  = dec_h[n-2] && !dec_h[n-3];
        m_lvl = lvl_h[n-1];
        if (m_ie && !m_de)      m_lvl = (m_lvl < 9) ? m_lvl + 1 : 9;
        else if (m_de && !m_ie) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
      end
      lvl_h[n] = m_lvl;
      m_k = n - s;
      if (!enable || m_k == 0) begin
        exp_pwm = 0; exp_ps = 0;
      end else begin
        m_p    = (m_k - 1) % PERIOD;
        m_per  = (m_k - 1) / PERIOD;
        m_duty = (m_per == 0) ? START_LEVEL : lvl_h[s + PERIOD * m_per - 1];
        exp_pwm = ((m_p / CLK_DIV) < m_duty) ? 1 : 0;
        exp_ps  = (m_p == 0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    check("level", int'(level), lvl_h[n]);
    check("pwm_out", int'(pwm_out), exp_pwm);
    check("period_start", int'(period_start), exp_ps);
    check("seg", int'(seg), int'(seg_tab[lvl_h[n]]));
  end

  task automatic wait_ps();
    int t = 0;
    while (period_start !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("ps_wait", int'(period_start), 1);
  endtask

  task automatic wait_pwm_high();
    int t = 0;
    while (pwm_out !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("pwm_wait", int'(pwm_out), 1);
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      hi += int'(pwm_out);
      @(negedge clk);
    end
  endtask

  task automatic pulse(input bit inc);
    if (inc) swt_inc = 1'b1; else swt_dec = 1'b1;
    repeat (3) @(negedge clk);
    swt_inc = 1'b0; swt_dec = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int hi, exp_l, hold;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_level", int'(level), 0);
    check("reset_seg", int'(seg), 7'b1000000);
    check("reset_pwm", int'(pwm_out), 0);

    enable = 1'b1;
    @(negedge clk);
    check("start_level", int'(level), START_LEVEL);
    wait_ps();
    count_high(hi);
    check("duty50", hi, 20);
    check("ps_period", int'(period_start), 1);

    exp_l = START_LEVEL;
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1);
      exp_l = (exp_l < 9) ? exp_l + 1 : 9;
      check("inc_step", int'(level), exp_l);
    end
    wait_ps();
    count_high(hi);
    check("duty90", hi, 36);

    for (int i = 0; i < 7; i++) pulse(1'b0);
    check("dec_to2", int'(level), 2);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0);
      check("dec_step", int'(level), (i == 0) ? 1 : 0);
    end
    wait_ps();
    count_high(hi);
    check("duty0", hi, 0);

    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("restart_level", int'(level), START_LEVEL);
    wait_ps();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 10) swt_inc = 1'b1;
      if (i == 13) swt_inc = 1'b0;
      hi += int'(pwm_out);
      @(negedge clk);
    end
    check("midperiod_old", hi, 20);
    count_high(hi);
    check("midperiod_new", hi, 24);

    swt_inc = 1'b1; swt_dec = 1'b1;
    repeat (3) @(negedge clk);
    swt_inc = 1'b0; swt_dec = 1'b0;
    repeat (3) @(negedge clk);
    check("simultaneous", int'(level), 6);
    swt_inc = 1'b1;
    repeat (200) @(negedge clk);
    swt_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("held_inc", int'(level), 7);

    wait_pwm_high();
    enable = 1'b0;
    @(negedge clk);
    check("stop_pwm", int'(pwm_out), 0);
    check("stop_level", int'(level), 0);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_level", int'(level), START_LEVEL);

    wait_pwm_high();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_level", int'(level), 0);
    en_h[n] = 0; lvl_h[n] = 0; exp_pwm = 0; exp_ps = 0;
    for (int i = 0; i < 3; i++) begin inc_h[n-i] = 0; dec_h[n-i] = 0; end
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) swt_inc = ~swt_inc;
      if ($urandom_range(7) == 0) swt_dec = ~swt_dec;
      if (enable && $urandom_range(399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(19) == 0) enable = 1'b1;
      @(negedge clk);
    end
    hold = int'(level);
    check("random_final_level", hold, lvl_h[n]);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_speed_gen.md
Name: pwm_speed_gen

Overview:
- Downstream of the operator-interface FSM, which only reports run/stop and raw increase/decrease switch levels.
- Owns the speed level (0–9, start value 5), turns switch edges into saturating level steps, and generates the motor PWM with duty = level × 10 %.
- Drives the active-low 7-segment digit that shows the current level.
- Runs in the single system clock domain.

Parameters:
- CLK_DIV, default 50: clk cycles per PWM slot (≥2). PWM period = 10 × CLK_DIV cycles.
- START_LEVEL, default 5: level loaded when the motor starts (0..9).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  motor-running flag from the interface FSM; synchronous to clk, not re-synchronised.
- swt_inc  in  1  raw increase switch; asynchronous, 2-FF synchronised internally.
- swt_dec  in  1  raw decrease switch; asynchronous, 2-FF synchronised internally.
- pwm_out  out  1  registered motor PWM.
- level  out  4  current speed level 0..9.
- seg  out  7  active-low 7-seg segments {g,f,e,d,c,b,a}.
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period while enabled.

Behaviour:
Reset (rst = 1, asynchronous):
- Clears synchronisers, edge registers, enable_q, prescaler, slot counter, duty shadow and level.
- Outputs: pwm_out = 0, level = 0, period_start = 0, seg = 7'b1000000 (shows "0").
- A mid-operation reset drops pwm_out within the reset assertion, with no clock required.

Input conditioning:
- Each switch passes through sync1 → sync2 → prev.
- Edge condition: inc_e = sync2 & ~prev; dec_e likewise.
- A switch rising before clk edge k causes the level update at edge k+2.
- Holding a switch high yields exactly one step; release and press again for the next step.

Enable tracking:
- enable_q registers enable.
- Start event: enable & ~enable_q. Stop event: ~enable.

Level register, priority from highest:
1. enable = 0: level ← 0; switch edges ignored.
2. Start event: level ← START_LEVEL; duty shadow ← START_LEVEL; any coincident switch edge is ignored.
3. inc_e & dec_e in the same cycle: hold.
4. inc_e: level ← min(level+1, 9). At level 9 it stays 9.
5. dec_e: level ← max(level−1, 0). At level 0 it stays 0, including while running.

PWM timing:
- While enable = 0, the prescaler (0..CLK_DIV−1) and slot counter (0..9) are held at 0.
- On the start event, both counters start from 0.
- tick = (prescaler == CLK_DIV−1). The slot increments on tick and wraps 9→0.
- Duty shadow is loaded from level only when tick & slot == 9, so a period is never modified mid-way. Exception: the start load above.
- pwm_out (registered) ← enable & (slot < shadow). This gives one cycle of latency from the counters.
- Level 0 → constant low. Level 9 → 90 %.
- On enable falling, pwm_out goes 0 at the next edge and the shadow clears to 0.
- period_start (registered) = 1 for the cycle in which slot == 0 and prescaler == 0 while enabled. This includes the first period after start.

Display:
- seg is combinational from level, active-low:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- Any other level value shows 0111111 (dash); it is unreachable.

Test Plan:
- Reset/start, CLK_DIV = 4: assert rst, then release with enable = 0 → pwm_out = 0, level = 0, seg = 1000000. Raise enable → level = 5 next edge, seg = 0010010, pwm_out high for 20 of every 40 cycles, period_start every 40 cycles.
- Increase saturation: enabled at 5, give 6 separate swt_inc pulses of 3 cycles each → level goes 6,7,8,9,9,9, each change 2 edges after the sync1 sample. After the next period boundary, pwm_out high 36 of 40 cycles.
- Decrease to zero: from level 2, give 3 swt_dec pulses → level 1, 0, 0. pwm_out is constant 0 after the boundary while enable stays 1.
- Mid-period change: change level 5→6 at slot 3 → the current period still has 20 high cycles; the next period has 24.
- Simultaneous/held inputs: swt_inc and swt_dec rise in the same cycle → level unchanged. Hold swt_inc high for 200 cycles → exactly one increment.
- Stop and async reset: drop enable mid-high-phase → pwm_out = 0 next edge, level = 0. Re-enable → level 5 again. Pulse rst between clock edges while pwm_out = 1 → pwm_out = 0 immediately.
